// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//
// Control FSM of the single-issue multi-cycle RISC-V core. Steps each
// instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK and drives
// the per-cycle enables for the datapath. It owns the single memory port,
// which it shares between instruction fetch (address = PC) and data
// load/store (address = ALU result). It also keeps the retired-instruction
// counter and a sticky trap for memory timeouts and illegal opcodes.
//
// Parameters
//   MEM_TIMEOUT    cycles mem_req may stay high without mem_ready before
//                  trapping (>= 2)
//   INSTRET_WIDTH  width of the retired-instruction counter
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            run request, sampled in IDLE and at each commit
//   write/store/load/branch, next_pc_selector
//                     instruction class and next-PC source from the decoder
//   branch_taken      branch comparator result, valid in EXECUTE
//   instr_legal       decoder recognised the opcode, valid in DECODE
//   mem_ready         memory accepts/completes the current request
//   mem_req, mem_we, mem_addr_sel
//                     shared memory port request, write enable, address select
//   ir_load           latch the instruction register
//   pc_write, pc_src  PC update enable and PC mux select
//   reg_write         register file write enable
//   retire, instret   commit pulse and retired-instruction count
//   trap, trap_cause  sticky fault flag and cause (01 timeout, 10 illegal)
//   state             current FSM state encoding
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
   parameter int unsigned MEM_TIMEOUT   = 16,
   parameter int unsigned INSTRET_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic                     write,
   input  logic                     store,
   input  logic                     load,
   input  logic                     branch,
   input  logic [1:0]               next_pc_selector,
   input  logic                     branch_taken,
   input  logic                     instr_legal,
   input  logic                     mem_ready,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic                     mem_addr_sel,
   output logic                     ir_load,
   output logic                     pc_write,
   output logic [1:0]               pc_src,
   output logic                     reg_write,
   output logic                     retire,
   output logic [INSTRET_WIDTH-1:0] instret,
   output logic                     trap,
   output logic [1:0]               trap_cause,
   output logic [2:0]               state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEMORY    = 3'd4,
      S_WRITEBACK = 3'd5,
      S_TRAP      = 3'd7
   } state_e;

   localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;

   // The wait counter only has to reach MEM_TIMEOUT-1: the stall cycle on
   // which it sits at that value is the one that raises the trap.
   localparam int unsigned           WAIT_W    = $clog2(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_e                     state_q, state_d;
   logic [WAIT_W-1:0]          wait_q, wait_d;
   logic [INSTRET_WIDTH-1:0]   instret_q;
   logic                       trap_q;
   logic [1:0]                 cause_q;

   logic                       commit;
   logic                       trap_set;
   logic [1:0]                 trap_set_cause;
   logic                       mem_stall;

   // --------------------------------------------------------------------------
   // Next-state and output decode
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default before the case so
      // that no path leaves a signal unassigned, which would infer a latch.
      state_d        = state_q;
      mem_req        = 1'b0;
      mem_we         = 1'b0;
      mem_addr_sel   = 1'b0;
      ir_load        = 1'b0;
      pc_write       = 1'b0;
      pc_src         = 2'b00;
      reg_write      = 1'b0;
      commit         = 1'b0;
      trap_set       = 1'b0;
      trap_set_cause = 2'b00;

      case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_FETCH;
         end

         S_FETCH: begin
            mem_req = 1'b1;
            ir_load = mem_ready;
            if (mem_ready) begin
               state_d = S_DECODE;
            end else if (wait_q == WAIT_LAST) begin
               trap_set       = 1'b1;
               trap_set_cause = CAUSE_TIMEOUT;
               state_d        = S_TRAP;
            end
         end

         S_DECODE: begin
            if (!instr_legal) begin
               trap_set       = 1'b1;
               trap_set_cause = CAUSE_ILLEGAL;
               state_d        = S_TRAP;
            end else begin
               state_d = S_EXECUTE;
            end
         end

         S_EXECUTE: begin
            if (load || store) begin
               state_d = S_MEMORY;
            end else if (write) begin
               state_d = S_WRITEBACK;
            end else begin
               // Branch commits here; a not-taken branch falls through to PC+4.
               commit   = 1'b1;
               pc_write = 1'b1;
               pc_src   = (branch && !branch_taken) ? 2'b00 : next_pc_selector;
            end
         end

         S_MEMORY: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = store;
            if (mem_ready) begin
               if (store) begin
                  commit   = 1'b1;
                  pc_write = 1'b1;
                  pc_src   = 2'b00;
               end else begin
                  state_d = S_WRITEBACK;
               end
            end else if (wait_q == WAIT_LAST) begin
               trap_set       = 1'b1;
               trap_set_cause = CAUSE_TIMEOUT;
               state_d        = S_TRAP;
            end
         end

         S_WRITEBACK: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            pc_src    = next_pc_selector;
            commit    = 1'b1;
         end

         S_TRAP: begin
            state_d = S_TRAP;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // enable is only looked at once the instruction has committed.
      if (commit) state_d = enable ? S_FETCH : S_IDLE;
   end

   // A stalled cycle is one where the port is requested but not served.
   assign mem_stall = mem_req && !mem_ready;

   // Any state change restarts the count, so entering FETCH or MEMORY
   // always begins at zero.
   always_comb begin
      wait_d = wait_q;
      if (state_d != state_q) begin
         wait_d = '0;
      end else if (mem_stall) begin
         wait_d = wait_q + WAIT_W'(1);
      end
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         wait_q    <= '0;
         instret_q <= '0;
         trap_q    <= 1'b0;
         cause_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (commit) instret_q <= instret_q + INSTRET_WIDTH'(1);
         if (trap_set) begin
            trap_q  <= 1'b1;
            cause_q <= trap_set_cause;
         end
      end
   end

   assign retire     = commit;
   assign instret    = instret_q;
   assign trap       = trap_q;
   assign trap_cause = cause_q;
   assign state      = state_q;

   // --------------------------------------------------------------------------
   // Structural invariants of the enables
   // --------------------------------------------------------------------------
   a_pc_src_idle : assert property (@(posedge clk) disable iff (!rst_n)
      !pc_write |-> (pc_src == 2'b00));

   a_enable_excl : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q != S_WRITEBACK) |-> $onehot0({ir_load, pc_write, reg_write}));

   a_trap_quiet : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == S_TRAP) |-> !(mem_req || ir_load || pc_write || reg_write || retire));

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Directed bench for multicycle_sequencer. Each instruction is described by
// its class, fetch/memory stall counts and next-PC data; the driver derives
// from the phase rules the list of cycles the instruction must take and what
// every output must be in each of them. A single compare process checks the
// DUT against that expectation on every falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

   localparam int unsigned MEM_TIMEOUT   = 16;
   localparam int unsigned INSTRET_WIDTH = 32;

   logic                     clk;
   logic                     rst_n;
   logic                     enable;
   logic                     write;
   logic                     store;
   logic                     load;
   logic                     branch;
   logic [1:0]               next_pc_selector;
   logic                     branch_taken;
   logic                     instr_legal;
   logic                     mem_ready;
   logic                     mem_req;
   logic                     mem_we;
   logic                     mem_addr_sel;
   logic                     ir_load;
   logic                     pc_write;
   logic [1:0]               pc_src;
   logic                     reg_write;
   logic                     retire;
   logic [INSTRET_WIDTH-1:0] instret;
   logic                     trap;
   logic [1:0]               trap_cause;
   logic [2:0]               state;

   multicycle_sequencer #(
      .MEM_TIMEOUT   (MEM_TIMEOUT),
      .INSTRET_WIDTH (INSTRET_WIDTH)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .enable           (enable),
      .write            (write),
      .store            (store),
      .load             (load),
      .branch           (branch),
      .next_pc_selector (next_pc_selector),
      .branch_taken     (branch_taken),
      .instr_legal      (instr_legal),
      .mem_ready        (mem_ready),
      .mem_req          (mem_req),
      .mem_we           (mem_we),
      .mem_addr_sel     (mem_addr_sel),
      .ir_load          (ir_load),
      .pc_write         (pc_write),
      .pc_src           (pc_src),
      .reg_write        (reg_write),
      .retire           (retire),
      .instret          (instret),
      .trap             (trap),
      .trap_cause       (trap_cause),
      .state            (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
   endtask

   typedef struct {
      logic [2:0] st;
      logic       req;
      logic       we;
      logic       asel;
      logic       irl;
      logic       pcw;
      logic [1:0] pcs;
      logic       rw;
      logic       ret;
      logic       trp;
      logic [1:0] cause;
   } exp_t;

   typedef enum {K_ALU, K_LOAD, K_STORE, K_BRANCH} kind_e;

   // Architectural model state
   logic [31:0] model_instret;
   logic        model_trap;
   logic [1:0]  model_cause;

   exp_t exp_cur;
   logic exp_valid = 1'b0;

   always @(negedge clk) begin
      if (exp_valid) begin
         check("state",        {29'd0, state},        {29'd0, exp_cur.st});
         check("mem_req",      {31'd0, mem_req},      {31'd0, exp_cur.req});
         check("mem_we",       {31'd0, mem_we},       {31'd0, exp_cur.we});
         check("mem_addr_sel", {31'd0, mem_addr_sel}, {31'd0, exp_cur.asel});
         check("ir_load",      {31'd0, ir_load},      {31'd0, exp_cur.irl});
         check("pc_write",     {31'd0, pc_write},     {31'd0, exp_cur.pcw});
         check("pc_src",       {30'd0, pc_src},       {30'd0, exp_cur.pcs});
         check("reg_write",    {31'd0, reg_write},    {31'd0, exp_cur.rw});
         check("retire",       {31'd0, retire},       {31'd0, exp_cur.ret});
         check("trap",         {31'd0, trap},         {31'd0, exp_cur.trp});
         check("trap_cause",   {30'd0, trap_cause},   {30'd0, exp_cur.cause});
         check("instret",      instret,               model_instret);
      end
   end

   // Quiet expectation for a given state with the current sticky trap status.
   function automatic exp_t quiet(input logic [2:0] st);
      exp_t e;
      e.st = st; e.req = 0; e.we = 0; e.asel = 0; e.irl = 0; e.pcw = 0;
      e.pcs = 2'b00; e.rw = 0; e.ret = 0;
      e.trp = model_trap; e.cause = model_cause;
      return e;
   endfunction

   // Inputs for the cycle are already driven; publish the expectation and
   // advance one clock, returning just after the rising edge.
   task automatic step(input exp_t e);
      exp_cur   = e;
      exp_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle(input logic en);
      enable = en;
      step(quiet(3'd0));
   endtask

   // Runs one instruction starting in FETCH. Decoder inputs are held for the
   // whole instruction; enable is driven to en_commit from EXECUTE onwards.
   task automatic run_instr(input kind_e k, input int fstall, input int mstall,
                            input logic taken, input logic [1:0] nps,
                            input logic en_commit, input logic legal,
                            output int cycles);
      exp_t e;
      cycles           = 0;
      enable           = 1'b1;
      write            = (k == K_ALU) || (k == K_LOAD);
      store            = (k == K_STORE);
      load             = (k == K_LOAD);
      branch           = (k == K_BRANCH);
      branch_taken     = taken;
      next_pc_selector = nps;
      instr_legal      = legal;

      for (int i = 0; i <= fstall; i++) begin
         mem_ready = (i == fstall);
         e = quiet(3'd1); e.req = 1'b1; e.irl = mem_ready;
         step(e); cycles++;
      end
      mem_ready = 1'b0;

      step(quiet(3'd2)); cycles++;
      if (!legal) begin
         model_trap  = 1'b1;
         model_cause = 2'b10;
         return;
      end

      enable = en_commit;
      e = quiet(3'd3);
      if (k == K_BRANCH) begin
         e.pcw = 1'b1; e.ret = 1'b1; e.pcs = taken ? nps : 2'b00;
         step(e); cycles++;
         model_instret++;
         return;
      end
      step(e); cycles++;

      if (k == K_LOAD || k == K_STORE) begin
         for (int i = 0; i <= mstall; i++) begin
            mem_ready = (i == mstall);
            e = quiet(3'd4); e.req = 1'b1; e.asel = 1'b1; e.we = (k == K_STORE);
            if (mem_ready && k == K_STORE) begin
               e.pcw = 1'b1; e.ret = 1'b1;
            end
            step(e); cycles++;
         end
         mem_ready = 1'b0;
         if (k == K_STORE) begin
            model_instret++;
            return;
         end
      end

      e = quiet(3'd5); e.rw = 1'b1; e.pcw = 1'b1; e.pcs = nps; e.ret = 1'b1;
      step(e); cycles++;
      model_instret++;
   endtask

   // Holds in TRAP for n cycles while toggling enable.
   task automatic trap_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         enable    = i[0];
         mem_ready = i[1];
         step(quiet(3'd7));
      end
   endtask

   task automatic apply_reset();
      exp_valid        = 1'b0;
      enable           = 1'b0;
      write            = 1'b0;
      store            = 1'b0;
      load             = 1'b0;
      branch           = 1'b0;
      next_pc_selector = 2'b00;
      branch_taken     = 1'b0;
      instr_legal      = 1'b1;
      mem_ready        = 1'b0;
      rst_n            = 1'b0;
      #2;
      check("rst_state",   {29'd0, state},      32'd0);
      check("rst_mem_req", {31'd0, mem_req},    32'd0);
      check("rst_instret", instret,             32'd0);
      check("rst_trap",    {31'd0, trap},       32'd0);
      check("rst_cause",   {30'd0, trap_cause}, 32'd0);
      check("rst_retire",  {31'd0, retire},     32'd0);
      model_instret = 0;
      model_trap    = 1'b0;
      model_cause   = 2'b00;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      int cyc;
      exp_t e;

      apply_reset();

      // R-type, zero-wait memory, followed by load with a 3-cycle stall.
      idle_cycle(1'b0);
      idle_cycle(1'b1);
      run_instr(K_ALU, 0, 0, 1'b0, 2'b01, 1'b1, 1'b1, cyc);
      check("alu_cycles", cyc, 32'd4);
      check("alu_instret_lit", instret, 32'd1);
      run_instr(K_LOAD, 0, 3, 1'b0, 2'b00, 1'b1, 1'b1, cyc);
      check("load_stall_cycles", cyc, 32'd8);

      // Branch not taken / taken with next_pc_selector = 10.
      run_instr(K_BRANCH, 0, 0, 1'b0, 2'b10, 1'b1, 1'b1, cyc);
      check("br_nt_cycles", cyc, 32'd3);
      run_instr(K_BRANCH, 0, 0, 1'b1, 2'b10, 1'b1, 1'b1, cyc);
      check("br_t_cycles", cyc, 32'd3);

      // Store with enable dropped in EXECUTE: commits, then IDLE.
      run_instr(K_STORE, 0, 0, 1'b0, 2'b00, 1'b0, 1'b1, cyc);
      check("store_cycles", cyc, 32'd4);
      idle_cycle(1'b0);
      check("instret_after_store_lit", instret, 32'd5);

      // Fetch served on the last stalled cycle before timeout: no trap.
      idle_cycle(1'b1);
      run_instr(K_ALU, MEM_TIMEOUT - 1, 0, 1'b0, 2'b11, 1'b1, 1'b1, cyc);
      check("late_fetch_cycles", cyc, 32'd19);

      // Fetch never served: trap after MEM_TIMEOUT stalled cycles.
      enable    = 1'b1;
      mem_ready = 1'b0;
      for (int i = 0; i < MEM_TIMEOUT; i++) begin
         e = quiet(3'd1); e.req = 1'b1;
         step(e);
      end
      model_trap  = 1'b1;
      model_cause = 2'b01;
      trap_cycles(6);
      check("timeout_cause_lit", {30'd0, trap_cause}, 32'd1);

      // Illegal instruction: trap from DECODE, instret unchanged.
      apply_reset();
      idle_cycle(1'b1);
      run_instr(K_ALU, 0, 0, 1'b0, 2'b01, 1'b1, 1'b0, cyc);
      trap_cycles(6);
      check("illegal_cause_lit", {30'd0, trap_cause}, 32'd2);
      check("illegal_instret_lit", instret, 32'd0);

      // Asynchronous reset in the middle of a stalled MEMORY phase.
      apply_reset();
      idle_cycle(1'b1);
      store     = 1'b1;
      load      = 1'b0;
      write     = 1'b0;
      branch    = 1'b0;
      mem_ready = 1'b1;
      e = quiet(3'd1); e.req = 1'b1; e.irl = 1'b1;
      step(e);
      mem_ready = 1'b0;
      step(quiet(3'd2));
      step(quiet(3'd3));
      for (int i = 0; i < 2; i++) begin
         e = quiet(3'd4); e.req = 1'b1; e.asel = 1'b1; e.we = 1'b1;
         step(e);
      end
      exp_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("async_rst_state",   {29'd0, state},   32'd0);
      apply_reset();

      // Recovery after reset: jalr-style instruction then stop.
      idle_cycle(1'b1);
      run_instr(K_ALU, 1, 0, 1'b0, 2'b11, 1'b0, 1'b1, cyc);
      check("recover_cycles", cyc, 32'd5);
      idle_cycle(1'b0);
      check("recover_instret_lit", instret, 32'd1);

      exp_valid = 1'b0;
      #10;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
